// File: rtl/axis_pkt_master.sv
// AXI-Stream packet source: bursts of fixed-length packets carrying an incrementing counter.
// Define AXIS_PKT_MASTER_GAP_EN to insert GAP_CYCLES idle cycles between packets of a burst.
//
// state | meaning
// IDLE  | waiting for start; zero-length requests answered with a done pulse
// SEND  | presenting beats; tlast marks the final beat of each packet
// GAP   | (AXIS_PKT_MASTER_GAP_EN only) tvalid low between packets
// DONE  | one-cycle completion, done=1, then IDLE
module axis_pkt_master #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast
);

`ifdef AXIS_PKT_MASTER_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  logic [GAP_W-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] pkt_cnt;
  logic             xfer;
  logic             last_pkt;
  logic             next_last;

  always_comb begin
    xfer      = m_tvalid & m_tready;
    last_pkt  = (pkt_cnt == num_q - CNT_W'(1));
    next_last = ((beat_cnt + LEN_W'(1)) == (len_q - LEN_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_q    <= '0;
      num_q    <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
`ifdef AXIS_PKT_MASTER_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (pkt_len != '0 && num_pkts != '0) begin
              len_q    <= pkt_len;
              num_q    <= num_pkts;
              m_tdata  <= seed;
              beat_cnt <= '0;
              pkt_cnt  <= '0;
              m_tvalid <= 1'b1;
              m_tlast  <= (pkt_len == LEN_W'(1));
              busy     <= 1'b1;
              state    <= SEND;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (xfer) begin
            m_tdata <= m_tdata + DATA_W'(1);
            // m_tlast doubles as "beat counter is at pkt_len-1"
            if (m_tlast) begin
              if (last_pkt) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end else begin
                beat_cnt <= '0;
                pkt_cnt  <= pkt_cnt + CNT_W'(1);
                m_tlast  <= (len_q == LEN_W'(1));
`ifdef AXIS_PKT_MASTER_GAP_EN
                m_tvalid <= 1'b0;
                gap_cnt  <= GAP_W'(GAP_CYCLES - 1);
                state    <= GAP;
`endif
              end
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
              m_tlast  <= next_last;
            end
          end
        end
`ifdef AXIS_PKT_MASTER_GAP_EN
        GAP: begin
          if (gap_cnt == '0) begin
            m_tvalid <= 1'b1;
            state    <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_pkt_master.md
Name: axis_pkt_master

Overview:
- AXI-Stream transmitter (master end) that generates bursts of fixed-length packets with tvalid/tready/tlast framing.
- Drives the stream slave receivers in the same design and serves as the bench/source stimulus block for them.
- Payload is an incrementing counter from a programmable seed, so the receiving end can check ordering and loss.

Parameters:
- DATA_W, 32, width of m_tdata
- LEN_W, 16, width of pkt_len and of the internal beat counter
- CNT_W, 8, width of num_pkts and of the internal packet counter
- GAP_CYCLES, 2, idle cycles between packets (used only when the optional feature is compiled in); must be >= 1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a burst; ignored while busy=1
- pkt_len  in  LEN_W  beats per packet; sampled on accepted start
- num_pkts  in  CNT_W  packets per burst; sampled on accepted start
- seed  in  DATA_W  first tdata value of the burst; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until the burst completes
- done  out  1  one-cycle pulse when the burst completes
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready from the slave
- m_tdata  out  DATA_W  stream data
- m_tlast  out  1  marks the final beat of each packet

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0; all counters cleared.
- Reset mid-burst: m_tvalid drops at that edge. No beat completes. After reset is released, the block waits in IDLE for a new start.
- All outputs are registered. m_tvalid never depends combinationally on m_tready.
- A beat transfers on any clk edge where m_tvalid=1 and m_tready=1.
- Stability rule: while m_tvalid=1 and m_tready=0, m_tvalid, m_tdata and m_tlast hold their values.
- States:
  - IDLE: start=1 with pkt_len!=0 and num_pkts!=0 -> latch pkt_len, num_pkts and seed; go to SEND. busy=1, m_tvalid=1, m_tdata=seed on the next cycle (1-cycle latency).
  - IDLE: start=1 with pkt_len==0 or num_pkts==0 -> stay in IDLE; done=1 for one cycle on the next cycle; no beats sent; busy stays 0.
  - SEND: on each transfer, m_tdata increments by 1, wrapping modulo 2^DATA_W. The beat counter increments.
  - SEND: m_tlast=1 exactly when beat counter == pkt_len-1.
  - SEND, last beat of a non-final packet transfers: beat counter clears, packet counter increments. Without the optional feature, m_tvalid stays 1 and the next packet's first beat is presented on the following cycle (back-to-back packets).
  - SEND, last beat of the final packet transfers: go to DONE.
  - DONE: lasts one cycle; m_tvalid=0, m_tlast=0, done=1, busy=0; then IDLE.
- start asserted while busy=1 or in DONE is ignored. It is not queued.
- Data runs continuously across packet boundaries within a burst. It does not restart at seed per packet.
- pkt_len=1 -> m_tlast=1 on every beat.

Optional Feature:
- Macro: AXIS_PKT_MASTER_GAP_EN.
- Defined: after a non-final packet's last beat transfers, the block enters GAP. In GAP, m_tvalid=0 for exactly GAP_CYCLES cycles, counted by a gap counter, then returns to SEND with the next beat. busy stays 1 during GAP. No gap follows the final packet.
- Undefined: the GAP state and the gap counter are absent; packets are sent back-to-back.

Test Plan:
- seed=0x10, pkt_len=4, num_pkts=1, m_tready=1 -> m_tvalid rises 1 cycle after start; tdata 0x10,0x11,0x12,0x13 on consecutive cycles; tlast only on 0x13; done pulses the next cycle; busy high 4 cycles.
- Same as above with m_tready toggling 1,0,0,1,... -> each beat held stable while ready=0; same 4 values in order; no duplicated or dropped beats.
- pkt_len=3, num_pkts=2, ready=1 -> 6 contiguous beats seed..seed+5; tlast on beats 3 and 6; m_tvalid never drops (macro undefined). With macro and GAP_CYCLES=2 -> m_tvalid=0 for exactly 2 cycles between beats 3 and 4.
- DATA_W=8, seed=0xFE, pkt_len=4 -> tdata 0xFE,0xFF,0x00,0x01; pkt_len=1, num_pkts=3 -> tlast on all 3 beats.
- pkt_len=0 -> no tvalid; done pulses once; busy stays 0. start pulsed again mid-burst -> ignored; beat count unchanged.
- rst=0 on beat 2 of a 5-beat packet -> next cycle m_tvalid=0, busy=0, done=0; a new start after release begins again from the newly sampled seed.
